// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus: stall requests and exceptions in, stall/flush/redirect
// and performance counters out.
interface pipe_ctrl_if;
    logic        stallreq_from_if;
    logic        stallreq_from_id;
    logic        stallreq_from_ex;
    logic        stallreq_from_mem;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic        perf_clr;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cnt;
    logic [31:0] bubble_cnt;
    logic [15:0] flush_cnt;
    logic        wdog_timeout;

    // Control unit side
    modport master (
        input  stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
        input  excepttype_i, cp0_epc_i, perf_clr,
        output stall, flush, new_pc, stall_cnt, bubble_cnt, flush_cnt, wdog_timeout
    );

    // Pipeline / CSR side
    modport slave (
        output stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
        output excepttype_i, cp0_epc_i, perf_clr,
        input  stall, flush, new_pc, stall_cnt, bubble_cnt, flush_cnt, wdog_timeout
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Central pipeline control: prioritised stall bus, exception/eret flush with
// post-flush mask window, saturating perf counters and a stall watchdog.
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
    parameter logic [31:0] ERET_CODE   = 32'h0000_000e,
    parameter int unsigned MASK_CYCLES = 2,
    parameter int unsigned WDOG_LIMIT  = 1024
) (
    input  logic          clk,
    input  logic          rst,
    pipe_ctrl_if.master   bus
);

    localparam int unsigned MW = (MASK_CYCLES < 1) ? 1 : $clog2(MASK_CYCLES + 1);
    localparam int unsigned RW = (WDOG_LIMIT < 1) ? 1 : $clog2(WDOG_LIMIT + 1);
    localparam int unsigned SW = 6;

    typedef enum logic [0:0] {ST_RUN, ST_MASK} state_t;

    state_t          r_state;
    logic [MW-1:0]   r_mask_cnt;
    logic [31:0]     r_stall_cnt;
    logic [31:0]     r_bubble_cnt;
    logic [15:0]     r_flush_cnt;
    logic [RW-1:0]   r_run_cnt;
    logic            r_wdog;

    logic            w_in_mask;
    logic            w_req_id;
    logic            w_req_ex;
    logic [SW-1:0]   w_stall;
    logic            w_flush;
    logic [31:0]     w_new_pc;
    logic            w_bubble;

    // id/ex requests are suppressed while the redirected fetch settles
    assign w_in_mask = (r_state == ST_MASK);
    assign w_req_id  = bus.stallreq_from_id & ~w_in_mask;
    assign w_req_ex  = bus.stallreq_from_ex & ~w_in_mask;

    always_comb begin
        w_stall  = '0;
        w_flush  = 1'b0;
        w_new_pc = '0;
        if (rst) begin
            w_stall = '0;
        end else if (bus.excepttype_i != 32'h0) begin
            w_flush  = 1'b1;
            w_new_pc = (bus.excepttype_i == ERET_CODE) ? bus.cp0_epc_i : EXC_VECTOR;
        end else if (bus.stallreq_from_mem) begin
            w_stall = 6'b011111;
        end else if (w_req_ex) begin
            w_stall = 6'b001111;
        end else if (w_req_id) begin
            w_stall = 6'b000111;
        end else if (bus.stallreq_from_if) begin
            w_stall = 6'b000011;
        end
    end

    assign w_bubble = w_stall[2] & ~w_stall[3];

    // Mask-window FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_mask_cnt <= '0;
        end else if (w_flush && (MASK_CYCLES != 0)) begin
            r_state    <= ST_MASK;
            r_mask_cnt <= MW'(MASK_CYCLES);
        end else if (r_state == ST_MASK) begin
            r_mask_cnt <= r_mask_cnt - MW'(1);
            if (r_mask_cnt <= MW'(1)) begin
                r_state <= ST_RUN;
            end
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst || bus.perf_clr) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (w_stall[0] && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_bubble && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
            if (w_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    // Watchdog: consecutive stalled cycles, sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst || bus.perf_clr) begin
            r_run_cnt <= '0;
            r_wdog    <= 1'b0;
        end else if (!w_stall[0] || w_flush) begin
            r_run_cnt <= '0;
        end else begin
            if (r_run_cnt != RW'(WDOG_LIMIT)) begin
                r_run_cnt <= r_run_cnt + RW'(1);
            end
            if (r_run_cnt >= RW'(WDOG_LIMIT - 1)) begin
                r_wdog <= 1'b1;
            end
        end
    end

    assign bus.stall        = w_stall;
    assign bus.flush        = w_flush;
    assign bus.new_pc       = w_new_pc;
    assign bus.stall_cnt    = r_stall_cnt;
    assign bus.bubble_cnt   = r_bubble_cnt;
    assign bus.flush_cnt    = r_flush_cnt;
    assign bus.wdog_timeout = r_wdog;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a short watchdog limit.
module tb_pipe_ctrl;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    pipe_ctrl_if u_if ();

    pipe_ctrl #(
        .EXC_VECTOR (32'h0000_0020),
        .ERET_CODE  (32'h0000_000e),
        .MASK_CYCLES(2),
        .WDOG_LIMIT (8)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(u_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, apply inputs, let combinational outputs settle
    task automatic cyc(input logic r, input logic s_if, input logic s_id, input logic s_ex,
                       input logic s_mem, input logic [31:0] exc, input logic [31:0] epc,
                       input logic clr);
        @(posedge clk);
        #1;
        rst                     = r;
        u_if.stallreq_from_if   = s_if;
        u_if.stallreq_from_id   = s_id;
        u_if.stallreq_from_ex   = s_ex;
        u_if.stallreq_from_mem  = s_mem;
        u_if.excepttype_i       = exc;
        u_if.cp0_epc_i          = epc;
        u_if.perf_clr           = clr;
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic chk_ctl(input string tag, input logic [5:0] st, input logic fl, input logic [31:0] pc);
        chk({tag, "_stall"}, 32'(u_if.stall), 32'(st));
        chk({tag, "_flush"}, 32'(u_if.flush), 32'(fl));
        chk({tag, "_newpc"}, u_if.new_pc, pc);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        u_if.stallreq_from_if  = 1'b0;
        u_if.stallreq_from_id  = 1'b0;
        u_if.stallreq_from_ex  = 1'b0;
        u_if.stallreq_from_mem = 1'b0;
        u_if.excepttype_i      = 32'h0;
        u_if.cp0_epc_i         = 32'h0;
        u_if.perf_clr          = 1'b0;

        // reset dominates all requests and exceptions
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1, 32'h1234, 1'b0);
        chk_ctl("rst_ctl", 6'b000000, 1'b0, 32'h0);
        idle();
        chk("rst_stall_cnt", u_if.stall_cnt, 32'd0);
        chk("rst_bubble_cnt", u_if.bubble_cnt, 32'd0);
        chk("rst_flush_cnt", 32'(u_if.flush_cnt), 32'd0);
        chk("rst_wdog", 32'(u_if.wdog_timeout), 32'd0);
        chk_ctl("idle", 6'b000000, 1'b0, 32'h0);

        // load-use stall for three cycles
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
            chk("id_stall", 32'(u_if.stall), 32'h07);
        end
        idle();
        chk("t1_stall_cnt", u_if.stall_cnt, 32'd3);
        chk("t1_bubble_cnt", u_if.bubble_cnt, 32'd3);

        // mem beats id; exception beats everything
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        chk("mem_id_stall", 32'(u_if.stall), 32'h1f);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1, 32'h0, 1'b0);
        chk_ctl("exc", 6'b000000, 1'b1, 32'h20);
        chk("t2_stall_cnt", u_if.stall_cnt, 32'd4);

        // eret inside the mask window: flush to EPC, window reloads
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'he, 32'h0040_0104, 1'b0);
        chk_ctl("eret", 6'b000000, 1'b1, 32'h0040_0104);
        chk("t3_flush_cnt", 32'(u_if.flush_cnt), 32'd1);

        // N+1: ex masked, if still acts
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("mask1_if", 32'(u_if.stall), 32'h03);
        chk("t3_flush_cnt2", 32'(u_if.flush_cnt), 32'd2);
        // N+2: ex still masked
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("mask2_ex", 32'(u_if.stall), 32'h00);
        // N+3: window closed
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("run_ex", 32'(u_if.stall), 32'h0f);
        idle();
        chk("t4_stall_cnt", u_if.stall_cnt, 32'd6);
        chk("t4_bubble_cnt", u_if.bubble_cnt, 32'd3);
        chk("t4_wdog", 32'(u_if.wdog_timeout), 32'd0);

        // eight consecutive stalled cycles trip the watchdog
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        end
        chk("wdog_before", 32'(u_if.wdog_timeout), 32'd0);
        idle();
        chk("wdog_set", 32'(u_if.wdog_timeout), 32'd1);
        chk("t5_stall_cnt", u_if.stall_cnt, 32'd14);
        idle();
        chk("wdog_sticky", 32'(u_if.wdog_timeout), 32'd1);

        // perf_clr wins over a qualifying cycle
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        idle();
        chk("clr_wdog", 32'(u_if.wdog_timeout), 32'd0);
        chk("clr_stall_cnt", u_if.stall_cnt, 32'd0);
        chk("clr_flush_cnt", 32'(u_if.flush_cnt), 32'd0);
        chk("clr_bubble_cnt", u_if.bubble_cnt, 32'd0);

        // eight stalled cycles broken by one idle: no timeout
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        idle();
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        idle();
        idle();
        chk("wdog_gap", 32'(u_if.wdog_timeout), 32'd0);
        chk("gap_stall_cnt", u_if.stall_cnt, 32'd8);

        // reset in the mask window returns straight to RUN
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4, 32'h0, 1'b0);
        chk("t6_flush", 32'(u_if.flush), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("t6_rst_stall", 32'(u_if.stall), 32'h00);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("t6_ex_after_rst", 32'(u_if.stall), 32'h0f);
        chk("t6_flush_cnt", 32'(u_if.flush_cnt), 32'd0);
        chk("t6_stall_cnt", u_if.stall_cnt, 32'd0);

        // mem still acts in the window; id masked then honoured
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0, 1'b0);
        chk_ctl("t7_exc", 6'b000000, 1'b1, 32'h20);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0);
        chk("mask_mem", 32'(u_if.stall), 32'h1f);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("mask_id", 32'(u_if.stall), 32'h00);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("run_id", 32'(u_if.stall), 32'h07);
        idle();
        chk("t7_bubble_cnt", u_if.bubble_cnt, 32'd1);
        chk("t7_flush_cnt", 32'(u_if.flush_cnt), 32'd1);
        chk("t7_stall_cnt", u_if.stall_cnt, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
